tage_ghr: RTL
=============

# tage_ghr

Global history register and folded-history generator feeding the TAGE predictor in the IFU. It keeps a speculative 80-bit global branch history, updated from each conditional-branch prediction, and a committed history, updated at commit. For each of the four TAGE tables (history lengths 10, 20, 40, 80) it maintains incrementally updated folded histories used for index and tag hashing. On `recover` the speculative state is restored from the committed state in one cycle.

## Interface
- `IDX_W`, default 10: index fold width per table.
- `TAG_W`, default 8: tag fold width per table.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous reset, active-low.
- `pause`  in  1  IFU stall; speculative update suppressed.
- `recover`  in  1  misprediction/exception flush; speculative state := committed state.
- `spec_valid`  in  1  a conditional branch was predicted this cycle.
- `spec_taken`  in  1  predicted direction (TAGE `pred_taken`).
- `commit_valid`  in  1  a conditional branch committed this cycle.
- `commit_taken`  in  1  resolved direction of the committing branch.
- `ghr`  out  80  speculative history; bit 0 is the newest outcome.
- `idx_fold`  out  4*IDX_W  speculative index folds; table i (L = 10·2^i) at `[i*IDX_W +: IDX_W]`.
- `tag_fold`  out  4*TAG_W  speculative tag folds; same table order.
- `commit_ghr`  out  80  committed history, for debug and checkpointing.

## Operation
- State:
  - speculative `ghr`, `idx_fold[4]`, `tag_fold[4]`;
  - committed `commit_ghr`, `c_idx_fold[4]`, `c_tag_fold[4]`.
- Shift with bit b: `h' = {h[78:0], b}`.
- Fold definition, which every fold register must equal at all times:
  - `fold_W(h,L)` = XOR of the W-bit chunks of `h[L-1:0]`, taken from bit 0 upward;
  - the last partial chunk is zero-extended.
- Incremental fold update with new bit b, outgoing bit `o = h[L-1]` (value before the shift), and `rotl1` as a 1-bit left rotate within W bits:
  - `f' = rotl1(f) ^ b ^ (o << (L mod W))`.
  - When `L mod W == 0`, o is XORed into bit 0 together with b.
- Committed path, evaluated every cycle independently of `pause` and `recover`:
  - if `commit_valid`, shift `commit_ghr` and the committed folds with `commit_taken`.
- Speculative path, in priority order:
  1. `recover`: spec state := committed state after this cycle's commit update. This includes the commit bit if `commit_valid` is high in the same cycle.
  2. else `pause`: hold; `spec_valid` is ignored.
  3. else `spec_valid`: shift spec state with `spec_taken`.
  4. else hold.
- No FSM; the block is two shift/fold register sets plus a restore mux. Folds are registered, never recomputed combinationally from the full GHR.

## Timing
- Reset (`rst` == 0 at a clk edge): all histories and folds become 0 on the next edge. All outputs read 0 in the cycle after reset.
- Update latency is 1 cycle: a `spec_valid` at edge n is visible on `ghr`/folds after edge n.
- Recover latency is 1 cycle: the cycle after `recover`, outputs equal committed state including any same-cycle commit.
- Outputs are register outputs only; there is no combinational path from any input to any output.
- Simultaneous `recover` and `spec_valid`: the prediction is dropped.
- Reset asserted during a `recover` or commit cycle: reset wins and everything clears.
- Wrap-around: after more than 80 shifts, the oldest bits are discarded. Folds stay consistent with the definition.

## Test plan
- Reset: drive arbitrary histories, assert `rst`=0 for one edge → `ghr`, `commit_ghr` and all folds = 0.
- Single shift: `spec_valid`=1, `spec_taken`=1 from reset → `ghr`=1 and every `idx_fold`/`tag_fold`=1 next cycle. `commit_ghr` stays 0.
- Pattern 1,0,1,1 (newest last), then `pause`=1 with `spec_valid`=1 for 3 cycles → `ghr`[3:0]=4'b1011, unchanged through the pause.
- Long run: 200 random spec shifts, with the bench recomputing `fold_W` directly each cycle → all 8 folds match every cycle. This includes the L=10/W=10, L=20/W=10 and L=80/W=8 cases with `L mod W`=0.
- Recover with same-cycle commit:
  - 5 taken spec shifts and 2 not-taken commits, then `recover`=1 with `commit_valid`=1, `commit_taken`=1;
  - → next cycle `ghr`=`commit_ghr`=3'b001 (zero above) and folds equal the committed folds.
- Recover with a simultaneous `spec_valid`=1 → the spec bit is dropped and `ghr` equals `commit_ghr`.

Source files
------------

// File: rtl/tage_ghr.sv
// tage_ghr: speculative and committed global branch history for the TAGE
// predictor, with incrementally maintained index/tag folds for four tables
// (history lengths 10, 20, 40, 80). Recover copies committed -> speculative.
//
// Handshake: a 1 on i_spec_valid or i_commit_valid in a cycle means exactly
// one branch outcome is presented that cycle. No ready exists: the block
// always accepts, except that i_pause or i_recover drops the speculative one.
module tage_ghr #(
   parameter int IDX_W = 10,
   parameter int TAG_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pause,
   input  logic                 i_recover,
   input  logic                 i_spec_valid,
   input  logic                 i_spec_taken,
   input  logic                 i_commit_valid,
   input  logic                 i_commit_taken,
   output logic [79:0]          o_ghr,
   output logic [4*IDX_W-1:0]   o_idx_fold,
   output logic [4*TAG_W-1:0]   o_tag_fold,
   output logic [79:0]          o_commit_ghr
);

   localparam int H_W   = 80;
   localparam int N_TBL = 4;

   logic [H_W-1:0]   r_ghr;
   logic [H_W-1:0]   r_c_ghr;
   logic [H_W-1:0]   w_ghr_shift;
   logic [H_W-1:0]   w_c_ghr_nxt;

   logic [IDX_W-1:0] r_idx_fold   [N_TBL];
   logic [IDX_W-1:0] r_c_idx_fold [N_TBL];
   logic [IDX_W-1:0] w_idx_shift  [N_TBL];
   logic [IDX_W-1:0] w_c_idx_nxt  [N_TBL];

   logic [TAG_W-1:0] r_tag_fold   [N_TBL];
   logic [TAG_W-1:0] r_c_tag_fold [N_TBL];
   logic [TAG_W-1:0] w_tag_shift  [N_TBL];
   logic [TAG_W-1:0] w_c_tag_nxt  [N_TBL];

   logic             w_spec_shift;

   assign w_spec_shift = i_spec_valid & ~i_pause;

   assign w_ghr_shift  = {r_ghr[H_W-2:0], i_spec_taken};
   assign w_c_ghr_nxt  = i_commit_valid ? {r_c_ghr[H_W-2:0], i_commit_taken} : r_c_ghr;

   // Per-table fold update: rotate left by one, insert the new bit at bit 0,
   // and cancel the bit leaving the window at offset (L mod W).
   for (genvar g = 0; g < N_TBL; g++) begin : g_tbl
      localparam int L      = 10 << g;
      localparam int IDX_SH = L % IDX_W;
      localparam int TAG_SH = L % TAG_W;

      assign w_idx_shift[g] = {r_idx_fold[g][IDX_W-2:0], r_idx_fold[g][IDX_W-1]}
                            ^ IDX_W'(i_spec_taken)
                            ^ (IDX_W'(r_ghr[L-1]) << IDX_SH);
      assign w_tag_shift[g] = {r_tag_fold[g][TAG_W-2:0], r_tag_fold[g][TAG_W-1]}
                            ^ TAG_W'(i_spec_taken)
                            ^ (TAG_W'(r_ghr[L-1]) << TAG_SH);

      assign w_c_idx_nxt[g] = i_commit_valid ?
                              ({r_c_idx_fold[g][IDX_W-2:0], r_c_idx_fold[g][IDX_W-1]}
                               ^ IDX_W'(i_commit_taken)
                               ^ (IDX_W'(r_c_ghr[L-1]) << IDX_SH))
                            : r_c_idx_fold[g];
      assign w_c_tag_nxt[g] = i_commit_valid ?
                              ({r_c_tag_fold[g][TAG_W-2:0], r_c_tag_fold[g][TAG_W-1]}
                               ^ TAG_W'(i_commit_taken)
                               ^ (TAG_W'(r_c_ghr[L-1]) << TAG_SH))
                            : r_c_tag_fold[g];

      assign o_idx_fold[g*IDX_W +: IDX_W] = r_idx_fold[g];
      assign o_tag_fold[g*TAG_W +: TAG_W] = r_tag_fold[g];
   end

   assign o_ghr        = r_ghr;
   assign o_commit_ghr = r_c_ghr;

   // Committed history: advances on every commit, regardless of pause/recover.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_c_ghr <= '0;
         for (int i = 0; i < N_TBL; i++) begin
            r_c_idx_fold[i] <= '0;
            r_c_tag_fold[i] <= '0;
         end
      end else begin
         r_c_ghr <= w_c_ghr_nxt;
         for (int i = 0; i < N_TBL; i++) begin
            r_c_idx_fold[i] <= w_c_idx_nxt[i];
            r_c_tag_fold[i] <= w_c_tag_nxt[i];
         end
      end
   end

   // Speculative history: recover restores post-commit state, else shift on an unpaused prediction.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_ghr <= '0;
         for (int i = 0; i < N_TBL; i++) begin
            r_idx_fold[i] <= '0;
            r_tag_fold[i] <= '0;
         end
      end else if (i_recover) begin
         r_ghr <= w_c_ghr_nxt;
         for (int i = 0; i < N_TBL; i++) begin
            r_idx_fold[i] <= w_c_idx_nxt[i];
            r_tag_fold[i] <= w_c_tag_nxt[i];
         end
      end else if (w_spec_shift) begin
         r_ghr <= w_ghr_shift;
         for (int i = 0; i < N_TBL; i++) begin
            r_idx_fold[i] <= w_idx_shift[i];
            r_tag_fold[i] <= w_tag_shift[i];
         end
      end
   end

endmodule
